// File: rtl/pow3_stream_checker.sv
// ---------------------------------------------------------------------------
// pow3_stream_checker
//
// AXI-Stream slave that sits directly after the power-of-3 generator. Beats
// are accepted into a small FIFO. While the checker is running, the host
// drains the FIFO with chk_drain. Each drained beat is compared against the
// expected power-of-3 sequence, where every value is the previous one times 3
// modulo 2^DATA_SIZE. Counters, a sticky error flag and the last drained value
// are exposed so the lab can observe the stream.
//
// Optional feature (compile-time macro POW3_CHK_STRB_EN):
//   When the macro is defined, an accepted beat with s00_axis_tstrb[0] == 0 is
//   consumed but not stored, and it is counted in chk_drop_count. When the
//   macro is undefined, tstrb is ignored and chk_drop_count is held at 0.
//
// Parameters:
//   DATA_SIZE   stream data width, a multiple of 8
//   FIFO_DEPTH  FIFO entries, a power of two and at least 2
//   INIT_EXP    expected value of the first beat after reset or clear
//
// Ports:
//   s00_axis_aclk     in   clock; all logic runs on its rising edge
//   s00_axis_areset   in   synchronous active-high reset
//   s00_axis_tdata    in   stream data
//   s00_axis_tstrb    in   byte strobes (only bit 0 is used, and only with the macro)
//   s00_axis_tvalid   in   beat valid
//   s00_axis_tlast    in   accepted but neither stored nor checked
//   s00_axis_tready   out  ready
//   chk_enable        in   run request
//   chk_drain         in   pop one FIFO entry per cycle while high
//   chk_halt_on_err   in   enter HALT on a mismatch
//   chk_clear         in   synchronous soft clear (same effect as reset)
//   chk_state         out  IDLE=00, RUN=01, HALT=10
//   chk_fifo_level    out  occupied FIFO entries
//   chk_beat_count    out  beats checked (saturating)
//   chk_err_count     out  mismatches (saturating)
//   chk_error         out  sticky mismatch flag
//   chk_last_data     out  last drained value
//   chk_drop_count    out  strobe-dropped beats (saturating)
//
// Handshake: a beat transfers on a rising edge where tvalid and tready are
// both 1. tready depends only on registers: it is 1 in RUN while the FIFO is
// not full. A pop in the same cycle does not raise tready, so a full FIFO
// never writes through. tvalid may be held with stable data until tready.
// ---------------------------------------------------------------------------
module pow3_stream_checker #(
  parameter int          DATA_SIZE  = 32,
  parameter int          FIFO_DEPTH = 4,
  parameter int unsigned INIT_EXP   = 3
) (
  input  logic                          s00_axis_aclk,
  input  logic                          s00_axis_areset,
  input  logic [DATA_SIZE-1:0]          s00_axis_tdata,
  input  logic [DATA_SIZE/8-1:0]        s00_axis_tstrb,
  input  logic                          s00_axis_tvalid,
  input  logic                          s00_axis_tlast,
  output logic                          s00_axis_tready,
  input  logic                          chk_enable,
  input  logic                          chk_drain,
  input  logic                          chk_halt_on_err,
  input  logic                          chk_clear,
  output logic [1:0]                    chk_state,
  output logic [$clog2(FIFO_DEPTH):0]   chk_fifo_level,
  output logic [31:0]                   chk_beat_count,
  output logic [15:0]                   chk_err_count,
  output logic                          chk_error,
  output logic [DATA_SIZE-1:0]          chk_last_data,
  output logic [15:0]                   chk_drop_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0]        DEPTH_L    = LW'(FIFO_DEPTH);
  localparam logic [DATA_SIZE-1:0] INIT_EXP_L = DATA_SIZE'(INIT_EXP);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_e;

  // Multiply by 3 as shift-and-add; the result is truncated to DATA_SIZE.
  function automatic logic [DATA_SIZE-1:0] times3(input logic [DATA_SIZE-1:0] x);
    return (x << 1) + x;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [DATA_SIZE-1:0]  expected_q, expected_d;
  logic [31:0]           beat_cnt_q, beat_cnt_d;
  logic [15:0]           err_cnt_q, err_cnt_d;
  logic                  err_q, err_d;
  logic [DATA_SIZE-1:0]  last_data_q, last_data_d;
  logic [DATA_SIZE-1:0]  mem_q [FIFO_DEPTH];

  // ---------------------------------------------------------------------------
  // Handshake, push and pop decode
  // ---------------------------------------------------------------------------
  logic                 ready;
  logic                 accept;
  logic                 store;
  logic                 pop;
  logic                 mismatch;
  logic [DATA_SIZE-1:0] head;

  always_comb begin
    ready    = (state_q == ST_RUN) && (level_q < DEPTH_L);
    accept   = s00_axis_tvalid && ready;
`ifdef POW3_CHK_STRB_EN
    // A beat whose lowest strobe is clear completes the handshake but is
    // discarded, so it never reaches the checker.
    store    = accept && s00_axis_tstrb[0];
`else
    store    = accept;
`endif
    pop      = (state_q == ST_RUN) && chk_drain && (level_q != '0);
    head     = mem_q[rd_ptr_q];
    mismatch = pop && (head != expected_q);
  end

  assign s00_axis_tready = ready;

  // ---------------------------------------------------------------------------
  // State machine: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (chk_enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        // A halting mismatch wins over a simultaneous drop of chk_enable.
        if (mismatch && chk_halt_on_err) state_d = ST_HALT;
        else if (!chk_enable)            state_d = ST_IDLE;
      end
      ST_HALT: begin
        // Only chk_clear leaves HALT; it is applied in the register block.
        state_d = ST_HALT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers and level: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (store) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({store, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Checker: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    expected_d  = expected_q;
    beat_cnt_d  = beat_cnt_q;
    err_cnt_d   = err_cnt_q;
    err_d       = err_q;
    last_data_d = last_data_q;
    if (pop) begin
      last_data_d = head;
      if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + 1'b1;
      if (mismatch) begin
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
        err_d      = 1'b1;
        // Resynchronise on the received value so that a single corrupted
        // beat is counted once and does not cascade.
        expected_d = times3(head);
      end else begin
        expected_d = times3(expected_q);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register update. Clear behaves exactly like reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset || chk_clear) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      expected_q  <= INIT_EXP_L;
      beat_cnt_q  <= '0;
      err_cnt_q   <= '0;
      err_q       <= 1'b0;
      last_data_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      expected_q  <= expected_d;
      beat_cnt_q  <= beat_cnt_d;
      err_cnt_q   <= err_cnt_d;
      err_q       <= err_d;
      last_data_q <= last_data_d;
    end
  end

  // FIFO storage has no reset; entries are only read between valid pointers.
  always_ff @(posedge s00_axis_aclk) begin
    if (store && !s00_axis_areset && !chk_clear) begin
      mem_q[wr_ptr_q] <= s00_axis_tdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Drop counter for strobe-filtered beats
  // ---------------------------------------------------------------------------
`ifdef POW3_CHK_STRB_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        drop;

  always_comb begin
    drop       = accept && !s00_axis_tstrb[0];
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset || chk_clear) drop_cnt_q <= '0;
    else                              drop_cnt_q <= drop_cnt_d;
  end

  assign chk_drop_count = drop_cnt_q;
`else
  assign chk_drop_count = '0;
`endif

  // tlast and the upper strobes carry no meaning for this checker.
  logic unused_inputs;
  assign unused_inputs = ^{s00_axis_tlast, s00_axis_tstrb};

  // ---------------------------------------------------------------------------
  // Observation outputs
  // ---------------------------------------------------------------------------
  assign chk_state      = state_q;
  assign chk_fifo_level = level_q;
  assign chk_beat_count = beat_cnt_q;
  assign chk_err_count  = err_cnt_q;
  assign chk_error      = err_q;
  assign chk_last_data  = last_data_q;

endmodule

// File: tb/tb_pow3_stream_checker.sv
module tb_pow3_stream_checker;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef POW3_CHK_STRB_EN
  localparam bit STRB_EN = 1'b1;
`else
  localparam bit STRB_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [DW-1:0]   tdata = '0;
  logic [DW/8-1:0] tstrb = '1;
  logic            tvalid = 1'b0;
  logic            tlast = 1'b0;
  logic            tready;
  logic            enable = 1'b0;
  logic            drain = 1'b0;
  logic            halt_on_err = 1'b0;
  logic            clear = 1'b0;
  logic [1:0]      state;
  logic [LW-1:0]   level;
  logic [31:0]     beat_count;
  logic [15:0]     err_count;
  logic            error;
  logic [DW-1:0]   last_data;
  logic [15:0]     drop_count;

  always #5 clk = ~clk;

  pow3_stream_checker #(.DATA_SIZE(DW), .FIFO_DEPTH(DEPTH), .INIT_EXP(3)) dut (
    .s00_axis_aclk   (clk),
    .s00_axis_areset (rst),
    .s00_axis_tdata  (tdata),
    .s00_axis_tstrb  (tstrb),
    .s00_axis_tvalid (tvalid),
    .s00_axis_tlast  (tlast),
    .s00_axis_tready (tready),
    .chk_enable      (enable),
    .chk_drain       (drain),
    .chk_halt_on_err (halt_on_err),
    .chk_clear       (clear),
    .chk_state       (state),
    .chk_fifo_level  (level),
    .chk_beat_count  (beat_count),
    .chk_err_count   (err_count),
    .chk_error       (error),
    .chk_last_data   (last_data),
    .chk_drop_count  (drop_count)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_vec  = 0;
  int n_miss = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The FIFO is an expected queue; the state is the spec code 0/1/2.
  logic [DW-1:0] exp_q[$];
  int            m_state;
  logic [DW-1:0] m_exp;
  logic [DW-1:0] m_last;
  logic [31:0]   m_beats;
  logic [15:0]   m_errs;
  logic          m_err;
  logic [15:0]   m_drops;
  bit            m_acc;
  bit            m_rc;

  task automatic model_reset();
    exp_q.delete();
    m_state = 0;
    m_exp   = 3;
    m_last  = 0;
    m_beats = 0;
    m_errs  = 0;
    m_err   = 0;
    m_drops = 0;
  endtask

  function automatic bit model_ready();
    return (m_state == 1) && (exp_q.size() < DEPTH);
  endfunction

  // One rising edge of the specification's rules, using the inputs present
  // at that edge and the model state from before it.
  task automatic model_step();
    bit            do_pop, bad;
    logic [DW-1:0] h;
    m_acc = 1'b0;
    m_rc  = rst || clear;
    if (rst || clear) begin
      model_reset();
      return;
    end
    m_acc  = tvalid && model_ready();
    do_pop = (m_state == 1) && drain && (exp_q.size() > 0);
    bad    = 1'b0;
    if (do_pop) begin
      h      = exp_q.pop_front();
      m_last = h;
      if (m_beats != 32'hFFFF_FFFF) m_beats++;
      if (h != m_exp) begin
        bad = 1'b1;
        if (m_errs != 16'hFFFF) m_errs++;
        m_err = 1'b1;
        m_exp = h * 3;
      end else begin
        m_exp = m_exp * 3;
      end
    end
    if (m_acc) begin
      if (STRB_EN && !tstrb[0]) begin
        if (m_drops != 16'hFFFF) m_drops++;
      end else begin
        exp_q.push_back(tdata);
      end
    end
    if (m_state == 0) begin
      if (enable) m_state = 1;
    end else if (m_state == 1) begin
      if (bad && halt_on_err) m_state = 2;
      else if (!enable)       m_state = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("state",      state,      m_state);
        check("tready",     tready,     model_ready());
        check("level",      level,      exp_q.size());
        check("beat_count", beat_count, m_beats);
        check("err_count",  err_count,  m_errs);
        check("error",      error,      m_err);
        check("last_data",  last_data,  m_last);
        check("drop_count", drop_count, m_drops);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
  endtask

  // Offer one beat and hold it until the handshake completes (bounded).
  task automatic push(input logic [DW-1:0] d, input logic [DW/8-1:0] s);
    tvalid = 1'b1;
    tdata  = d;
    tstrb  = s;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (tready) begin
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        return;
      end
    end
    n_vec++;
    n_miss++;
    $display("FAIL push_timeout @%0t: got no tready, expected a handshake for %0d", $time, d);
    @(posedge clk);
    #1;
    tvalid = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  logic [DW-1:0] v;
  logic [DW-1:0] gen;
  int            r;

  initial begin
    rst = 1'b1;
    idle(2);
    cmp_en = 1'b1;
    // reset values
    check("rst_state",  state, 0);
    check("rst_tready", tready, 0);
    check("rst_level",  level, 0);
    check("rst_last",   last_data, 0);
    rst = 1'b0;

    // Straight sequence with drain held high
    enable = 1'b1;
    drain  = 1'b1;
    push(3, '1); push(9, '1); push(27, '1); push(81, '1);
    idle(4);
    check("a_beats", beat_count, 4);
    check("a_errs",  err_count, 0);
    check("a_error", error, 0);
    check("a_last",  last_data, 81);
    check("a_model_exp", m_exp, 243);

    // Fill with drain low, then drain under continuous push
    clear_pulse();
    drain = 1'b0;
    push(3, '1); push(9, '1); push(27, '1); push(81, '1);
    tvalid = 1'b1;
    tdata  = 243;
    idle(3);
    check("b_full_tready", tready, 0);
    check("b_full_level",  level, 4);
    drain = 1'b1;
    push(243, '1); push(729, '1); push(2187, '1);
    idle(6);
    check("b_beats", beat_count, 7);
    check("b_errs",  err_count, 0);
    check("b_last",  last_data, 2187);

    // Single corrupted beat and resync
    clear_pulse();
    push(3, '1); push(9, '1); push(28, '1); push(84, '1);
    idle(4);
    check("c_errs",  err_count, 1);
    check("c_error", error, 1);
    check("c_beats", beat_count, 4);
    check("c_last",  last_data, 84);

    // Halt on error, enable ignored in HALT, then clear
    clear_pulse();
    halt_on_err = 1'b1;
    push(3, '1); push(10, '1); push(30, '1);
    idle(3);
    check("d_state",  state, 2);
    check("d_tready", tready, 0);
    check("d_level",  level, 1);
    check("d_last",   last_data, 10);
    enable = 1'b0;
    idle(2);
    check("d_halt_hold", state, 2);
    enable = 1'b1;
    clear_pulse();
    check("d_clr_state", state, 0);
    check("d_clr_level", level, 0);
    check("d_clr_beats", beat_count, 0);
    check("d_clr_errs",  err_count, 0);
    check("d_clr_model_exp", m_exp, 3);
    halt_on_err = 1'b0;

    // Wrap-around: 3^1 .. 3^21
    v = 3;
    for (int i = 0; i < 21; i++) begin
      push(v, '1);
      v = v * 3;
    end
    idle(4);
    check("e_last",  last_data, 32'd1870418611);
    check("e_errs",  err_count, 0);
    check("e_beats", beat_count, 21);

    // Strobe-dropped beat
    clear_pulse();
    push(3, '1); push(5, '0); push(9, '1);
    idle(4);
`ifdef POW3_CHK_STRB_EN
    check("f_drops", drop_count, 1);
    check("f_errs",  err_count, 0);
    check("f_beats", beat_count, 2);
`else
    check("f_drops", drop_count, 0);
    check("f_errs",  err_count, 2);
    check("f_beats", beat_count, 3);
`endif

    // Randomised traffic checked cycle by cycle against the model
    clear_pulse();
    gen = 3;
    for (int c = 0; c < 2500; c++) begin
      if (m_rc)       gen = 3;
      else if (m_acc) gen = gen * 3;
      r           = $urandom_range(0, 199);
      rst         = (r == 0);
      clear       = (r >= 1 && r <= 3);
      enable      = ($urandom_range(0, 15) != 0);
      drain       = ($urandom_range(0, 3) != 0);
      halt_on_err = ($urandom_range(0, 7) == 0);
      tvalid      = ($urandom_range(0, 3) != 0);
      tdata       = ($urandom_range(0, 19) == 0) ? DW'($urandom) : gen;
      tstrb       = DW'($urandom) | (($urandom_range(0, 9) != 0) ? 4'h1 : 4'h0);
      tlast       = $urandom_range(0, 1);
      idle(1);
    end
    rst    = 1'b0;
    clear  = 1'b0;
    tvalid = 1'b0;
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
